// File: rtl/vscale_dmem_bridge_if.sv
// Word-bus side of the data-memory bridge: one valid/ready request channel
// (address, read/write, byte mask, write data) and a read response channel.
interface vscale_dmem_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_rw;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [3:0]            mem_req_wmask;
    logic [31:0]           mem_req_wdata;
    logic                  mem_resp_valid;
    logic [31:0]           mem_resp_rdata;

    modport master (
        output mem_req_valid,
        input  mem_req_ready,
        output mem_req_rw,
        output mem_req_addr,
        output mem_req_wmask,
        output mem_req_wdata,
        input  mem_resp_valid,
        input  mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_req_rw,
        input  mem_req_addr,
        input  mem_req_wmask,
        input  mem_req_wdata,
        output mem_resp_valid,
        output mem_resp_rdata
    );
endinterface

// File: rtl/vscale_dmem_bridge.sv
// Bridges the core's split-phase data-memory port (request in DX, store data
// and load data in WB) onto a single valid/ready word bus with byte masks.
// Handles store lane replication, load extraction/extension, misalignment
// detection and the stall signal back to the core.
module vscale_dmem_bridge #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dmem_en,
    input  logic                  dmem_wen,
    input  logic [2:0]            dmem_size,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [31:0]           dmem_wdata_delayed,
    output logic [31:0]           dmem_rdata,
    output logic                  dmem_wait,
    output logic                  dmem_badmem_e,
    vscale_dmem_bridge_if.master  bus
);

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            size_q, size_d;
    logic                  wen_q, wen_d;

    logic                  capture;
    logic                  size_illegal;
    logic                  misaligned;
    logic [15:0]           lane16;

    // Misalignment / illegal-size detection on the live DX request
    always_comb begin
        size_illegal = (dmem_size == 3'd3) || (dmem_size == 3'd6) || (dmem_size == 3'd7);
        misaligned   = 1'b0;
        if ((dmem_size == SZ_H) || (dmem_size == SZ_HU)) begin
            misaligned = dmem_addr[0];
        end else if (dmem_size == SZ_W) begin
            misaligned = (dmem_addr[1:0] != 2'b00);
        end
        dmem_badmem_e = dmem_en & (size_illegal | misaligned);
    end

    // Stall: held until a store is accepted or a load response returns
    always_comb begin
        dmem_wait = 1'b0;
        unique case (state_q)
            S_IDLE: dmem_wait = 1'b0;
            S_REQ:  dmem_wait = wen_q ? ~bus.mem_req_ready : 1'b1;
            S_RESP: dmem_wait = ~bus.mem_resp_valid;
            default: dmem_wait = 1'b0;
        endcase
        capture = dmem_en & ~dmem_badmem_e & ~dmem_wait;
    end

    // Next-state and request-register update
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wen_d   = wen_q;
        if (capture) begin
            addr_d = dmem_addr;
            size_d = dmem_size;
            wen_d  = dmem_wen;
        end
        unique case (state_q)
            S_IDLE: begin
                if (capture) state_d = S_REQ;
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    if (!wen_q)       state_d = S_RESP;
                    else if (capture) state_d = S_REQ;
                    else              state_d = S_IDLE;
                end
            end
            S_RESP: begin
                if (bus.mem_resp_valid) state_d = capture ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wen_q   <= wen_d;
        end
    end

    // Bus request fields, all from registered request plus held WB store data
    always_comb begin
        bus.mem_req_valid = (state_q == S_REQ);
        bus.mem_req_rw    = wen_q;
        bus.mem_req_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        bus.mem_req_wmask = '0;
        bus.mem_req_wdata = dmem_wdata_delayed;
        unique case (size_q[1:0])
            2'b00: begin
                bus.mem_req_wdata = {4{dmem_wdata_delayed[7:0]}};
                if (wen_q) bus.mem_req_wmask = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                bus.mem_req_wdata = {2{dmem_wdata_delayed[15:0]}};
                if (wen_q) bus.mem_req_wmask = 4'b0011 << {addr_q[1], 1'b0};
            end
            default: begin
                if (wen_q) bus.mem_req_wmask = 4'b1111;
            end
        endcase
    end

    // Load extraction: lane select is the low 16 bits of rdata >> 8*addr[1:0]
    always_comb begin
        unique case (addr_q[1:0])
            2'd0: lane16 = bus.mem_resp_rdata[15:0];
            2'd1: lane16 = bus.mem_resp_rdata[23:8];
            2'd2: lane16 = bus.mem_resp_rdata[31:16];
            default: lane16 = {8'h00, bus.mem_resp_rdata[31:24]};
        endcase
        dmem_rdata = '0;
        if ((state_q == S_RESP) && bus.mem_resp_valid) begin
            unique case (size_q)
                SZ_B:    dmem_rdata = {{24{lane16[7]}}, lane16[7:0]};
                SZ_BU:   dmem_rdata = {24'h000000, lane16[7:0]};
                SZ_H:    dmem_rdata = {{16{lane16[15]}}, lane16};
                SZ_HU:   dmem_rdata = {16'h0000, lane16};
                default: dmem_rdata = bus.mem_resp_rdata;
            endcase
        end
    end

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// Directed bench for vscale_dmem_bridge: stores, loads with extension,
// misaligned accesses, back-to-back transactions and reset mid-load.
module tb_vscale_dmem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        dmem_en;
    logic        dmem_wen;
    logic [2:0]  dmem_size;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata_delayed;
    logic [31:0] dmem_rdata;
    logic        dmem_wait;
    logic        dmem_badmem_e;

    int errors = 0;
    int checks = 0;

    vscale_dmem_bridge_if #(.ADDR_WIDTH(32)) bus ();

    vscale_dmem_bridge #(.ADDR_WIDTH(32)) dut (
        .clk                (clk),
        .reset              (reset),
        .dmem_en            (dmem_en),
        .dmem_wen           (dmem_wen),
        .dmem_size          (dmem_size),
        .dmem_addr          (dmem_addr),
        .dmem_wdata_delayed (dmem_wdata_delayed),
        .dmem_rdata         (dmem_rdata),
        .dmem_wait          (dmem_wait),
        .dmem_badmem_e      (dmem_badmem_e),
        .bus                (bus.master)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        dmem_en = 1'b0; dmem_wen = 1'b0; dmem_size = 3'd0; dmem_addr = '0;
        dmem_wdata_delayed = '0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus.mem_req_valid); end
        checks++; if (dmem_wait !== 1'b0) begin errors++; $display("FAIL reset_wait got=%0b exp=0", dmem_wait); end
        checks++; if (dmem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", dmem_rdata); end
        checks++; if (bus.mem_req_wmask !== 4'h0) begin errors++; $display("FAIL reset_wmask got=%h exp=0", bus.mem_req_wmask); end
        checks++; if (bus.mem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.mem_req_addr); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Store with ready=1 in first REQ cycle; never stalls
    task automatic do_store(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                            input logic [31:0] exp_wdata, input string name);
        @(negedge clk);
        dmem_en = 1'b1; dmem_wen = 1'b1; dmem_size = size; dmem_addr = addr; #1;
        checks++; if (dmem_wait !== 1'b0) begin errors++; $display("FAIL %s dx_wait got=%0b exp=0", name, dmem_wait); end
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL %s dx_valid got=%0b exp=0", name, bus.mem_req_valid); end
        @(negedge clk);
        dmem_en = 1'b0; dmem_wdata_delayed = wd; bus.mem_req_ready = 1'b1; #1;
        checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL %s valid got=%0b exp=1", name, bus.mem_req_valid); end
        checks++; if (bus.mem_req_rw !== 1'b1) begin errors++; $display("FAIL %s rw got=%0b exp=1", name, bus.mem_req_rw); end
        checks++; if (bus.mem_req_addr !== exp_addr) begin errors++; $display("FAIL %s addr got=%h exp=%h", name, bus.mem_req_addr, exp_addr); end
        checks++; if (bus.mem_req_wmask !== exp_mask) begin errors++; $display("FAIL %s wmask got=%b exp=%b", name, bus.mem_req_wmask, exp_mask); end
        checks++; if (bus.mem_req_wdata !== exp_wdata) begin errors++; $display("FAIL %s wdata got=%h exp=%h", name, bus.mem_req_wdata, exp_wdata); end
        checks++; if (dmem_wait !== 1'b0) begin errors++; $display("FAIL %s req_wait got=%0b exp=0", name, dmem_wait); end
        @(negedge clk);
        bus.mem_req_ready = 1'b0; #1;
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL %s after_valid got=%0b exp=0", name, bus.mem_req_valid); end
        checks++; if (dmem_wait !== 1'b0) begin errors++; $display("FAIL %s after_wait got=%0b exp=0", name, dmem_wait); end
    endtask

    task automatic test_store_word();
        do_store(3'd2, 32'h104, 32'hDEADBEEF, 32'h104, 4'b1111, 32'hDEADBEEF, "sw_104");
    endtask

    task automatic test_store_byte_half();
        do_store(3'd0, 32'h203, 32'h000000A5, 32'h200, 4'b1000, 32'hA5A5A5A5, "sb_203");
        do_store(3'd1, 32'h206, 32'h1234BEEF, 32'h204, 4'b1100, 32'hBEEFBEEF, "sh_206");
    endtask

    // Load with `stall` ready-low REQ cycles, then one RESP cycle
    task automatic do_load(input logic [2:0] size, input logic [31:0] addr, input int stall,
                           input logic [31:0] resp, input logic [31:0] exp_rdata, input string name);
        int wait_cycles;
        wait_cycles = 0;
        @(negedge clk);
        dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = size; dmem_addr = addr;
        for (int i = 0; i <= stall; i++) begin
            @(negedge clk);
            dmem_en = 1'b0; bus.mem_req_ready = (i == stall); #1;
            if (dmem_wait === 1'b1) wait_cycles++;
            checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL %s req_valid cyc=%0d got=%0b exp=1", name, i, bus.mem_req_valid); end
        end
        checks++; if (bus.mem_req_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL %s addr got=%h exp=%h", name, bus.mem_req_addr, {addr[31:2], 2'b00}); end
        checks++; if (bus.mem_req_wmask !== 4'h0 || bus.mem_req_rw !== 1'b0) begin errors++; $display("FAIL %s load_fields got=%b/%b exp=0000/0", name, bus.mem_req_wmask, bus.mem_req_rw); end
        @(negedge clk);
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = resp; #1;
        checks++; if (dmem_rdata !== exp_rdata) begin errors++; $display("FAIL %s rdata got=%h exp=%h", name, dmem_rdata, exp_rdata); end
        checks++; if (dmem_wait !== 1'b0) begin errors++; $display("FAIL %s resp_wait got=%0b exp=0", name, dmem_wait); end
        checks++; if (wait_cycles != stall + 1) begin errors++; $display("FAIL %s wait_cycles got=%0d exp=%0d", name, wait_cycles, stall + 1); end
        @(negedge clk);
        bus.mem_resp_valid = 1'b0; #1;
        checks++; if (dmem_rdata !== 32'h0 || bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL %s idle got=%h/%0b exp=0/0", name, dmem_rdata, bus.mem_req_valid); end
    endtask

    task automatic test_load_extend();
        do_load(3'd0, 32'h102, 3, 32'h0080FF11, 32'hFFFFFF80, "lb_102");
        do_load(3'd4, 32'h102, 3, 32'h0080FF11, 32'h00000080, "lbu_102");
        do_load(3'd1, 32'h100, 0, 32'h0080FF11, 32'hFFFFFF11, "lh_100");
        do_load(3'd5, 32'h100, 1, 32'h0080FF11, 32'h0000FF11, "lhu_100");
        do_load(3'd0, 32'h101, 0, 32'h0080FF11, 32'hFFFFFFFF, "lb_101");
        do_load(3'd2, 32'h108, 0, 32'hCAFEF00D, 32'hCAFEF00D, "lw_108");
    endtask

    task automatic test_misaligned();
        logic [2:0]  sizes [4];
        logic [31:0] addrs [4];
        sizes = '{3'd1, 3'd2, 3'd3, 3'd5};
        addrs = '{32'h101, 32'h102, 32'h100, 32'h103};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = sizes[i]; dmem_addr = addrs[i]; #1;
            checks++; if (dmem_badmem_e !== 1'b1) begin errors++; $display("FAIL bad_%0d badmem got=%0b exp=1", i, dmem_badmem_e); end
            checks++; if (dmem_wait !== 1'b0) begin errors++; $display("FAIL bad_%0d wait got=%0b exp=0", i, dmem_wait); end
            @(negedge clk);
            dmem_en = 1'b0; #1;
            checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL bad_%0d valid got=%0b exp=0", i, bus.mem_req_valid); end
            checks++; if (dmem_badmem_e !== 1'b0) begin errors++; $display("FAIL bad_%0d en_low got=%0b exp=0", i, dmem_badmem_e); end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h100;
        @(negedge clk);
        dmem_en = 1'b0; bus.mem_req_ready = 1'b1;
        @(negedge clk);
        // RESP completes while the next store is presented in DX
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'h12345678;
        dmem_en = 1'b1; dmem_wen = 1'b1; dmem_size = 3'd2; dmem_addr = 32'h104; #1;
        checks++; if (dmem_rdata !== 32'h12345678) begin errors++; $display("FAIL b2b_rdata got=%h exp=12345678", dmem_rdata); end
        checks++; if (dmem_wait !== 1'b0) begin errors++; $display("FAIL b2b_resp_wait got=%0b exp=0", dmem_wait); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_resp_valid = 1'b0; dmem_wdata_delayed = 32'hCAFEF00D;
            // A different request held in DX during the stall must not be taken
            dmem_en = (i < 2); dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h300;
            bus.mem_req_ready = (i == 2); #1;
            checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid cyc=%0d got=%0b exp=1", i, bus.mem_req_valid); end
            checks++; if (bus.mem_req_addr !== 32'h104 || bus.mem_req_rw !== 1'b1) begin errors++; $display("FAIL b2b_addr cyc=%0d got=%h/%0b exp=104/1", i, bus.mem_req_addr, bus.mem_req_rw); end
            checks++; if (bus.mem_req_wmask !== 4'hF || bus.mem_req_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_data cyc=%0d got=%h/%h exp=f/cafef00d", i, bus.mem_req_wmask, bus.mem_req_wdata); end
            checks++; if (dmem_wait !== (i < 2)) begin errors++; $display("FAIL b2b_wait cyc=%0d got=%0b exp=%0b", i, dmem_wait, (i < 2)); end
        end
        @(negedge clk);
        bus.mem_req_ready = 1'b0; #1;
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got=%0b exp=0", bus.mem_req_valid); end
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h100;
        @(negedge clk);
        dmem_en = 1'b0; bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0; #1;
        checks++; if (dmem_wait !== 1'b1) begin errors++; $display("FAIL rst_resp_wait got=%0b exp=1", dmem_wait); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'h87654321; #1;
        checks++; if (dmem_wait !== 1'b0) begin errors++; $display("FAIL rst_wait got=%0b exp=0", dmem_wait); end
        checks++; if (dmem_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", dmem_rdata); end
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", bus.mem_req_valid); end
        @(negedge clk);
        bus.mem_resp_valid = 1'b0; #1;
        checks++; if (bus.mem_req_valid !== 1'b0 || dmem_wait !== 1'b0) begin errors++; $display("FAIL rst_after got=%0b/%0b exp=0/0", bus.mem_req_valid, dmem_wait); end
        checks++; if (bus.mem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", bus.mem_req_addr); end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_byte_half();
        test_load_extend();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vscale_dmem_bridge.md
Name: vscale_dmem_bridge

Overview:
- Sits directly downstream of the core's data-memory port; consumes its DX-phase request and WB-phase store data.
- Converts the core's split-phase interface (address/size/wen in DX, store data one cycle later in WB, read data expected in WB) into a single valid/ready word-bus transaction with byte masks.
- Performs load byte/halfword extraction and sign/zero extension, store lane replication, and misalignment detection.
- Generates dmem_wait to stall the core until the transaction completes.

Parameters:
- ADDR_WIDTH, 32, width of core and bus byte addresses.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dmem_en  in  1  core requests a memory access this DX cycle
- dmem_wen  in  1  1 = store, 0 = load
- dmem_size  in  3  funct3 encoding: 0 B, 1 H, 2 W, 4 BU, 5 HU
- dmem_addr  in  ADDR_WIDTH  byte address, valid in DX
- dmem_wdata_delayed  in  32  store data, valid in the cycle after capture, held while stalled
- dmem_rdata  out  32  extracted and extended load data, valid when a load completes
- dmem_wait  out  1  stall request to the core
- dmem_badmem_e  out  1  misaligned or illegal-size access, combinational in DX
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts the request
- mem_req_rw  out  1  1 = write
- mem_req_addr  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0
- mem_req_wmask  out  4  byte write enables
- mem_req_wdata  out  32  lane-replicated store data
- mem_resp_valid  in  1  read response valid
- mem_resp_rdata  in  32  raw read word

Behaviour:
- Misalignment:
  - dmem_badmem_e = dmem_en & (H/HU with addr[0]=1, W with addr[1:0]!=0, or size in {3, 6, 7}).
  - A flagged access is never captured and never reaches the bus.
- Capture:
  - Occurs at posedge when dmem_en & ~dmem_badmem_e & ~dmem_wait.
  - Registers addr, size, wen, and moves the FSM to REQ.
  - While dmem_wait=1, the core holds DX and no new capture occurs.
- FSM states are IDLE, REQ, RESP.
  - IDLE: mem_req_valid=0, dmem_wait=0. Goes to REQ on capture.
  - REQ: mem_req_valid=1, fields derived from registered addr/size/wen and combinational dmem_wdata_delayed.
    - Store with ready=1: completes this cycle; dmem_wait=0. Goes to REQ if a new capture occurs, otherwise IDLE.
    - Load with ready=1: goes to RESP; dmem_wait=1.
    - ready=0: stays in REQ; dmem_wait=1.
    - Once mem_req_valid is asserted, all request fields stay stable until ready.
  - RESP: mem_req_valid=0.
    - mem_resp_valid=1: dmem_wait=0, dmem_rdata valid the same cycle. Goes to REQ on a new capture, otherwise IDLE.
    - mem_resp_valid=0: dmem_wait=1.
- Bus rule: the response arrives no earlier than the cycle after acceptance, so loads take at least one wait cycle.
- Store lanes:
  - B: wdata = {4{wd[7:0]}}, wmask = 4'b0001 << addr[1:0].
  - H: wdata = {2{wd[15:0]}}, wmask = 4'b0011 << {addr[1],1'b0}.
  - W: wdata = wd, wmask = 4'b1111.
  - Loads: wmask = 0.
- Load extract:
  - sh = rdata >> (8*addr[1:0]).
  - B = sext(sh[7:0]), BU = zext(sh[7:0]), H = sext(sh[15:0]), HU = zext(sh[15:0]), W = rdata.
- dmem_rdata outside load completion is a don't-care; drive 0.
- mem_resp_valid in IDLE or REQ is ignored.
- Reset values: state IDLE, mem_req_valid=0, dmem_wait=0, dmem_rdata=0, mem_req_wmask=0, registered addr/size/wen=0.
- Reset mid-operation: the outstanding transaction is dropped without a retry. A response arriving afterwards is ignored.
- Back-to-back: a completion cycle with a simultaneous capture goes straight to REQ with no idle bubble.

Test Plan:
1. SW addr 0x104, wd 0xDEADBEEF, ready=1 in the first REQ cycle → one bus write: addr 0x104, wmask 1111, wdata 0xDEADBEEF; dmem_wait stays 0 throughout.
2. SB addr 0x203, wd 0x000000A5 → wdata 0xA5A5A5A5, wmask 1000, mem_req_addr 0x200.
3. LB addr 0x102 with ready after 3 cycles, resp 0x0080FF11 one cycle later:
   - dmem_wait high for 4 cycles.
   - On the response cycle dmem_rdata = 0xFFFFFF80; the same address with LBU gives 0x00000080.
4. LH addr 0x101 and LW addr 0x102 → dmem_badmem_e=1, mem_req_valid never asserts, dmem_wait stays 0.
5. Back-to-back LW 0x100 then SW 0x104, resp 0x12345678 → no IDLE cycle between them; second request fields stable while ready is held low.
6. Reset asserted while in RESP, late mem_resp_valid=1 → FSM in IDLE, dmem_wait=0, dmem_rdata=0, no bus request.
